serial_div_sched: RTL
=====================

# serial_div_sched

Front-end scheduler and sequencer for the serial divisible-by-5 residue datapath. It accepts parallel words from up to NREQ requesters and grants one word at a time by round-robin arbitration. It shifts the granted word MSB-first through an internal mod-5 residue state machine and returns a result tagged with the requester index. It lets several producers share one serial divide-by-5 checker without each driving its own serial stream.

## Interface
- WIDTH, 8, bits per request word (2..32)
- NREQ, 4, number of requesters (2..8); IDW = max(1, clog2(NREQ))
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low; all state cleared while low
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i] at a rising edge
- ser_vld  out  1  serial bit valid (high in each SHIFT cycle)
- ser_bit  out  1  current serial bit, MSB-first
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, result valid
- div5  out  1  1 when the completed word mod 5 == 0
- res_rem  out  3  completed word mod 5 (0..4)
- res_id  out  IDW  requester index of the completed word

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - req_ready is combinational: one-hot of the first asserted req_valid, searching from (ptr+1) mod NREQ upward.
  - On a handshake:
    - capture the word into shift_reg and the index into id_reg
    - ptr <= granted index; rem <= 0; cnt <= WIDTH
    - next state = SHIFT
  - No req_valid: req_ready = 0, remain in IDLE.
- SHIFT, one bit per cycle:
  - ser_bit = shift_reg[WIDTH-1]; ser_vld = 1
  - rem <= (2*rem + ser_bit) mod 5, computed in 4 bits then reduced; rem is never outside 0..4
  - shift_reg <<= 1; cnt <= cnt-1
  - When cnt == 1, next state = DONE.
- DONE:
  - done = 1; div5 = (rem == 0); res_rem = rem; res_id = id_reg
  - next state = IDLE
- req_ready = 0 in SHIFT and DONE. Requesters hold req_valid and req_data until granted; a deasserted request is never granted.
- div5, res_rem and res_id hold their last values until the next DONE.
- Round-robin: ptr resets to NREQ-1, so requester 0 has highest priority after reset. A requester that was just granted has lowest priority for the next grant.

## Timing
- Reset values: req_ready=0 (combinational, IDLE with no valid), ser_vld=0, ser_bit=0, busy=0, done=0, div5=0, res_rem=0, res_id=0, ptr=NREQ-1.
- Handshake at edge E0. SHIFT occupies cycles E0+1..E0+WIDTH. done is high in cycle E0+WIDTH+1.
- Next grant is possible at edge E0+WIDTH+2, giving a throughput of one word per WIDTH+2 cycles.
- Simultaneous valids are resolved only by the round-robin order; a grant is never split.
- Reset asserted mid-SHIFT or mid-DONE: the word is abandoned, no done pulse, and all outputs return to reset values immediately.
- A req_valid change during SHIFT has no effect on the word in flight.

## Configuration
- SERIAL_DIV_LZ_SKIP_EN defined:
  - On capture, cnt is loaded with WIDTH - lz, where lz is the leading-zero count of the word, and shift_reg is pre-aligned so its MSB is the leading 1.
  - Leading zeros are never emitted on ser_*.
  - An all-zero word skips SHIFT: IDLE goes directly to DONE, done is high at E0+1, and div5=1, res_rem=0.
  - Residue results are unchanged because leading zeros do not alter the residue.
- SERIAL_DIV_LZ_SKIP_EN undefined: every word takes exactly WIDTH SHIFT cycles, as described above.

## Test plan
- WIDTH=8, req0 word 0x05 → ser_bit sequence 0,0,0,0,0,1,0,1; done at E0+9; div5=1, res_rem=0, res_id=0.
- req1 word 0x09 → res_rem=4, div5=0, res_id=1. req3 word 0xFF → res_rem=0, div5=1.
- req0 and req2 both held valid from reset → grant order 0, 2, 0, 2; req_ready never asserted outside IDLE; at most one req_ready bit high.
- rst driven low during the 4th SHIFT cycle of word 0x0A → no done pulse, outputs at reset values; a subsequent req0 word 0x0A → div5=1.
- Back-to-back: req0 valid continuously with words 0x0A then 0x07 → second handshake exactly WIDTH+2 cycles after the first; results div5=1, then res_rem=2.
- With SERIAL_DIV_LZ_SKIP_EN: word 0x05 → 3 SHIFT cycles with bits 1,0,1 and done at E0+4; word 0x00 → done at E0+1, div5=1.

Source files
------------

// File: rtl/serial_div_sched.sv
// serial_div_sched: round-robin front end feeding an MSB-first serial mod-5 residue checker.
// Define SERIAL_DIV_LZ_SKIP_EN to strip leading zeros from each captured word before shifting.
module serial_div_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  ser_vld,
    output logic                  ser_bit,
    output logic                  busy,
    output logic                  done,
    output logic                  div5,
    output logic [2:0]            res_rem,
    output logic [IDW-1:0]        res_id
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] shift_reg, word;
    logic [CW-1:0] cnt;
    logic [2:0] rem, nrem;
    logic [3:0] twice;
    logic [IDW-1:0] ptr, id_reg, gidx, k;
    logic [NREQ-1:0] grant;
    logic found;
    // Search starts just past the last winner, so it drops to lowest priority.
    always_comb begin
        grant = '0;
        gidx = '0;
        found = 1'b0;
        k = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[k]) begin
                found = 1'b1;
                grant[k] = 1'b1;
                gidx = k;
            end
        end
    end
    assign word = req_data[gidx*WIDTH +: WIDTH];
    assign req_ready = (state == IDLE) ? grant : '0;
    assign ser_vld = (state == SHIFT);
    assign ser_bit = ser_vld & shift_reg[WIDTH-1];
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign twice = {rem, shift_reg[WIDTH-1]};
    assign nrem = (twice >= 4'd5) ? 3'(twice - 4'd5) : twice[2:0];
`ifdef SERIAL_DIV_LZ_SKIP_EN
    logic [CW-1:0] lz;
    always_comb begin
        lz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (word[i]) lz = CW'(WIDTH - 1 - i);
    end
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shift_reg <= '0;
            cnt <= '0;
            rem <= '0;
            id_reg <= '0;
            ptr <= IDW'(NREQ - 1);
            div5 <= 1'b0;
            res_rem <= '0;
            res_id <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    id_reg <= gidx;
                    ptr <= gidx;
                    rem <= '0;
`ifdef SERIAL_DIV_LZ_SKIP_EN
                    shift_reg <= word << lz;
                    cnt <= CW'(WIDTH) - lz;
                    if (lz == CW'(WIDTH)) begin
                        state <= DONE;
                        div5 <= 1'b1;
                        res_rem <= '0;
                        res_id <= gidx;
                    end else state <= SHIFT;
`else
                    shift_reg <= word;
                    cnt <= CW'(WIDTH);
                    state <= SHIFT;
`endif
                end
                SHIFT: begin
                    rem <= nrem;
                    shift_reg <= shift_reg << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        div5 <= (nrem == 3'd0);
                        res_rem <= nrem;
                        res_id <= id_reg;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
